// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronizes the PLL lock flag, qualifies it for a
// programmable stable time before releasing the downstream reset, filters
// short lock dropouts, and holds reset for a minimum time after a real loss.
// Loss events are recorded in a sticky flag and a saturating counter.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int DROP_FILTER   = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lock,
  input  logic             clear_sticky,
  output logic             rst_out,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state_dbg
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int DW = (DROP_FILTER   > 1) ? $clog2(DROP_FILTER)   : 1;
  localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;

  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(DROP_FILTER - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            lock_meta, lock_s;
  logic [SW-1:0]   scnt, scnt_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic            enter_lost;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  // State and qualification/drop/hold counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_LOCK;
      scnt  <= '0;
      dcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      dcnt  <= dcnt_n;
      hcnt  <= hcnt_n;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_n    = state;
    scnt_n     = scnt;
    dcnt_n     = dcnt;
    hcnt_n     = hcnt;
    enter_lost = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABILIZE;
          scnt_n  = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end else if (scnt == SMAX) begin
          state_n = RUN;
          dcnt_n  = '0;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      RUN: begin
        if (lock_s) begin
          dcnt_n = '0;
        end else if (dcnt == DMAX) begin
          state_n    = LOST;
          hcnt_n     = '0;
          enter_lost = 1'b1;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      LOST: begin
        if (hcnt == HMAX) begin
          state_n = WAIT_LOCK;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  // Loss bookkeeping: sticky flag (set beats clear) and saturating counter
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      if (enter_lost) begin
        lock_lost <= 1'b1;
        if (loss_count != '1) begin
          loss_count <= loss_count + CNT_W'(1);
        end
      end else if (clear_sticky) begin
        lock_lost <= 1'b0;
      end
    end
  end

  assign rst_out   = (state != RUN);
  assign ready     = (state == RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: segment table, hand sequences for the
// multi-cycle corners, then random lock waveforms against a run-length model.
module tb_pll_reset_sequencer;

  localparam int S  = 8;
  localparam int DF = 4;
  localparam int H  = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          lock;
  logic          clear_sticky;
  logic          rst_out;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] loss_count;
  logic [1:0]    state_dbg;

  int checks;
  int errors;

  pll_reset_sequencer #(
    .STABLE_CYCLES(S),
    .DROP_FILTER(DF),
    .HOLD_CYCLES(H),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .lock(lock),
    .clear_sticky(clear_sticky),
    .rst_out(rst_out),
    .ready(ready),
    .lock_lost(lock_lost),
    .loss_count(loss_count),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the FSM sees lock as sampled two edges earlier.
  // Qualification is a streak of observed highs: streak 0 waits, 1..S
  // stabilizes, reaching S+1 releases. In run, a streak of DF lows is a loss.
  // A loss holds reset for exactly H edges, ignoring lock.
  int m_mode;   // 0 qualify, 1 run, 2 hold
  int m_streak;
  int m_lows;
  int m_age;
  int m_cnt;
  bit m_sticky;
  bit h0, h1;

  function automatic void model_edge(input bit l, input bit r, input bit c);
    bit ls;
    bit ev;
    ev = 1'b0;
    if (r) begin
      m_mode = 0; m_streak = 0; m_lows = 0; m_age = 0;
      m_cnt = 0; m_sticky = 1'b0; h0 = 1'b0; h1 = 1'b0;
      return;
    end
    ls = h1;
    h1 = h0;
    h0 = l;
    case (m_mode)
      0: begin
        if (ls) begin
          m_streak++;
          if (m_streak == S + 1) begin
            m_mode = 1;
            m_lows = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
      1: begin
        if (ls) m_lows = 0;
        else begin
          m_lows++;
          if (m_lows == DF) begin
            m_mode = 2;
            m_age = 0;
            ev = 1'b1;
          end
        end
      end
      default: begin
        if (m_age == H - 1) begin
          m_mode = 0;
          m_streak = 0;
        end else begin
          m_age++;
        end
      end
    endcase
    if (ev) begin
      m_sticky = 1'b1;
      if (m_cnt < CMAX) m_cnt++;
    end else if (c) begin
      m_sticky = 1'b0;
    end
  endfunction

  function automatic int model_state();
    if (m_mode == 0) return (m_streak == 0) ? 0 : 1;
    if (m_mode == 1) return 2;
    return 3;
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // One clock edge: drive inputs, advance the model, sample #1 after the edge
  task automatic step(input bit l, input bit r, input bit c);
    int st;
    lock = l;
    reset = r;
    clear_sticky = c;
    @(posedge clock);
    model_edge(l, r, c);
    #1;
    st = model_state();
    chk("m_state", int'(state_dbg), st);
    chk("m_rst_out", int'(rst_out), (st == 2) ? 0 : 1);
    chk("m_ready", int'(ready), (st == 2) ? 1 : 0);
    chk("m_lock_lost", int'(lock_lost), int'(m_sticky));
    chk("m_loss_count", int'(loss_count), m_cnt);
  endtask

  task automatic chk_all(input string name, input int st, input int ro, input int cnt, input int ll);
    chk({name, "_state"}, int'(state_dbg), st);
    chk({name, "_rst_out"}, int'(rst_out), ro);
    chk({name, "_ready"}, int'(ready), 1 - ro);
    chk({name, "_count"}, int'(loss_count), cnt);
    chk({name, "_lost"}, int'(lock_lost), ll);
  endtask

  // From steady RUN with lock high: 6 low steps enter LOST, 25 high return to RUN
  task automatic do_loss(input int ec, input bit ce, input int ell);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, ce);
    chk_all("loss_entry", 3, 1, ec, ell);
    repeat (25) step(1'b1, 1'b0, 1'b0);
    chk("loss_rerun_state", int'(state_dbg), 2);
  endtask

  typedef struct {
    bit lck;
    bit clr;
    int n;
    int st;
    int ro;
    int cnt;
    int ll;
  } seg_t;

  seg_t segs[10];

  initial begin
    checks = 0;
    errors = 0;
    lock = 1'b0;
    reset = 1'b1;
    clear_sticky = 1'b0;
    model_edge(1'b0, 1'b1, 1'b0);

    segs[0] = '{1'b1, 1'b0, 10, 1, 1, 0, 0}; // edges 1..10 still qualifying
    segs[1] = '{1'b1, 1'b0,  1, 2, 0, 0, 0}; // edge 11 releases
    segs[2] = '{1'b0, 1'b0,  3, 2, 0, 0, 0}; // 3-cycle dropout
    segs[3] = '{1'b1, 1'b0,  5, 2, 0, 0, 0}; // dropout filtered
    segs[4] = '{1'b0, 1'b0,  6, 3, 1, 1, 1}; // real loss reaches LOST
    segs[5] = '{1'b1, 1'b0, 15, 3, 1, 1, 1}; // held despite lock back
    segs[6] = '{1'b1, 1'b0,  1, 0, 1, 1, 1}; // hold expires
    segs[7] = '{1'b1, 1'b0,  1, 1, 1, 1, 1}; // requalify starts
    segs[8] = '{1'b1, 1'b0,  8, 2, 0, 1, 1}; // released again
    segs[9] = '{1'b1, 1'b1,  1, 2, 0, 1, 0}; // clear_sticky alone

    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("reset", 0, 1, 0, 0);

    for (int unsigned i = 0; i < 10; i++) begin
      for (int k = 0; k < segs[i].n; k++) step(segs[i].lck, 1'b0, segs[i].clr);
      chk_all($sformatf("seg%0d", i), segs[i].st, segs[i].ro, segs[i].cnt, segs[i].ll);
    end

    // Glitch during STABILIZE restarts the full qualification
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("glitch_restart", int'(state_dbg), 0);
    for (int k = 9; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("glitch_no_early", int'(rst_out), 1);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("glitch_release", int'(state_dbg), 2);

    // Saturation and sticky-flag priority
    do_loss(1, 1'b0, 1);
    do_loss(2, 1'b0, 1);
    do_loss(3, 1'b0, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("clear_alone", int'(lock_lost), 0);
    do_loss(3, 1'b1, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("clear_again", int'(lock_lost), 0);
    do_loss(3, 1'b0, 1);

    // Reset from RUN and from LOST
    step(1'b1, 1'b1, 1'b0);
    chk_all("rst_in_run", 0, 1, 0, 0);
    repeat (11) step(1'b1, 1'b0, 1'b0);
    chk("rerelease", int'(state_dbg), 2);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk_all("lost_before_rst", 3, 1, 1, 1);
    step(1'b0, 1'b1, 1'b0);
    chk_all("rst_in_lost", 0, 1, 0, 0);

    // Random lock waveforms with occasional clears and resets
    begin
      int steps;
      steps = 0;
      while (steps < 4000) begin
        bit lvl;
        int len;
        lvl = 1'($urandom_range(0, 1));
        len = (($urandom_range(0, 3) == 0) ? 20 : 1) + int'($urandom_range(0, 9));
        for (int k = 0; k < len; k++) begin
          step(lvl, ($urandom_range(0, 999) == 0), ($urandom_range(0, 15) == 0));
          steps++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Consumer side of the ECP5 PLL wrapper. Runs in the PLL output clock domain and takes the PLL's asynchronous lock flag. Produces a clean synchronous reset for all downstream logic. The reset releases only after lock has been stable for a programmable time, and it re-asserts when lock is lost, with loss events recorded for debug.

Parameters:
STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before reset release (>=1)
DROP_FILTER, 4, consecutive synchronized-lock-low cycles in RUN that count as a real lock loss (>=1)
HOLD_CYCLES, 16, minimum cycles rst_out is held in LOST before lock is re-evaluated (>=1)
CNT_W, 8, width of the lock-loss event counter

Ports:
clock  input  1  PLL output clock; all logic on rising edge
reset  input  1  synchronous, active-high block reset
lock  input  1  PLL lock flag, asynchronous to clock
clear_sticky  input  1  single-cycle pulse; clears lock_lost
rst_out  output  1  active-high synchronous reset to downstream logic
ready  output  1  high exactly when state==RUN (equals ~rst_out)
lock_lost  output  1  sticky flag, set on every entry into LOST
loss_count  output  CNT_W  number of LOST entries, saturating
state_dbg  output  2  encoding WAIT_LOCK=0, STABILIZE=1, RUN=2, LOST=3

Behaviour:
- Reset is synchronous and active-high:
  - state=WAIT_LOCK
  - both sync flops=0, all counters=0
  - rst_out=1, ready=0, lock_lost=0, loss_count=0
- Reset mid-operation, from any state, returns to these values on the next edge.
- lock passes through a 2-flop synchronizer; lock_s is the second flop's output. Only lock_s is used after the synchronizer.
- rst_out, ready and state_dbg are decoded from the registered state: rst_out = (state!=RUN).
- WAIT_LOCK:
  - if lock_s=1: go to STABILIZE and set scnt=0
  - else stay
- STABILIZE:
  - if lock_s=0: go to WAIT_LOCK (glitch restarts qualification)
  - else if scnt==STABLE_CYCLES-1: go to RUN
  - else scnt+=1
- Release latency: lock is first sampled high at edge 1 and stays high. Then lock_s=1 at edge 2, STABILIZE at edge 3, and RUN plus rst_out=0 at edge STABLE_CYCLES+3.
- RUN:
  - dcnt counts consecutive lock_s=0 cycles; any lock_s=1 clears dcnt to 0.
  - When lock_s=0 and dcnt==DROP_FILTER-1: go to LOST and set hcnt=0.
  - Dropouts shorter than DROP_FILTER cycles are ignored; rst_out stays 0.
- On the edge entering LOST:
  - lock_lost<=1
  - loss_count<=loss_count+1 unless already 2^CNT_W-1 (saturates, no wrap)
- LOST:
  - rst_out=1
  - hcnt counts up; at hcnt==HOLD_CYCLES-1 go to WAIT_LOCK
  - lock_s is ignored while in LOST
- clear_sticky clears lock_lost. If clear_sticky and a LOST entry occur on the same edge, set wins and lock_lost=1.
- clear_sticky does not affect loss_count; only reset clears loss_count.
- Counter widths are clog2 of their respective parameter, minimum 1 bit. No counter may overflow for any legal parameter value.

Test Plan:
1. Reset release with STABLE_CYCLES=8, lock=1 from the first edge after reset -> rst_out=1 through edge 10, rst_out=0 and ready=1 at edge 11, state_dbg sequence 0,0,1..1,2.
2. Glitch during STABILIZE: lock drops for 1 cycle after 5 high cycles -> state returns to 0 and the full 8-cycle qualification restarts; rst_out never falls early.
3. Short dropout in RUN with DROP_FILTER=4: lock low for 3 cycles -> rst_out stays 0, loss_count=0, lock_lost=0.
4. Real loss in RUN: lock low for 4+ cycles -> LOST entered, rst_out=1, loss_count=1, lock_lost=1. rst_out is held for HOLD_CYCLES=16 even if lock returns immediately, then re-qualifies and releases.
5. Sticky and saturation with CNT_W=2: force 5 loss events -> loss_count=3 after the third event and stays 3. clear_sticky on the same edge as a LOST entry leaves lock_lost=1; clear_sticky alone gives lock_lost=0.
6. Reset asserted while in RUN and while in LOST -> next edge gives state=0, rst_out=1, counters=0, lock_lost=0.
